// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } cla_seq_state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: every carry is computed directly from g/p and cin.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms: no carry depends on a previous carry signal.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder reusing one cla4_slice, with valid/ready on both sides.
// Optional macro CLA_SEQ_SUB_EN adds a `sub` input for a - b (cout=1 means no borrow).
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  cla_seq_state_t      state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W+1:0]    bitpos;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                accept;
  logic                sub_sel;
  logic                last_step;

  assign in_ready  = (state == S_IDLE) & rst_n;
  assign accept    = in_valid & in_ready;
  assign bitpos    = {idx, 2'b00};
  assign last_step = (idx == IDX_W'(NIB - 1));

`ifdef CLA_SEQ_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign slice_a = a_q[bitpos +: NIBBLE_W];
  assign slice_b = b_q[bitpos +: NIBBLE_W];

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Operand registers are pure data: loaded on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub_sel ? ~b : b;
    end
  end

  // Control FSM plus the registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            carry_q <= sub_sel ? 1'b1 : cin;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum[bitpos +: NIBBLE_W] <= slice_sum;
          carry_q                 <= slice_cout;
          if (last_step) begin
            cout      <= slice_cout;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl at WIDTH=16; build with CLA_SEQ_SUB_EN to cover subtraction.
module tb_cla_seq_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks;
  int failures;

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid after an accepting edge; returns edges counted (bounded).
  task automatic wait_result(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [15:0] esum, input logic ecout);
    int n;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    wait_result(n);
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, out_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_rdy_again"}, in_ready, 1'b1);
  endtask

  initial begin
    int n;
    logic [15:0] held_sum;
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic adds and full carry propagation
    run_op("t1", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("t3a", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("t3b", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("t3c", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0);

    // Back-pressure in DONE with new operands offered
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    wait_result(n);
    check("t4_latency", n, 4);
    check("t4_sum", sum, 16'hBCDE);
    held_sum = sum;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold_sum", sum, held_sum);
      check("t4_hold_cout", cout, 1'b0);
      check("t4_hold_ov", out_valid, 1'b1);
      check("t4_hold_rdy", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_ret_ov", out_valid, 1'b0);
    check("t4_ret_rdy", in_ready, 1'b1);
    check("t4_ret_busy", busy, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("t4_new_busy", busy, 1'b1);
    wait_result(n);
    check("t4_new_latency", n, 4);
    check("t4_new_sum", sum, 16'h1010);
    check("t4_new_cout", cout, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_ov", out_valid, 1'b0);
    check("t5_sum", sum, 16'h0000);
    check("t5_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t5_rdy", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5_no_ov", out_valid, 1'b0);
    end
    run_op("t5_after", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    run_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
